// File: rtl/op1_sub_pipe.sv
// Two-stage 8-bit subtract on a 12-bit operand bus: the low nibble resolves in
// stage 1, the high nibble in stage 2 using the registered nibble carry.

module op1_sub_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] diff_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  // A - B computed as A + ~B + cin with a 4-bit carry lookahead.
  always_comb begin
    g    = a_i & ~b_i;
    p    = a_i ^ ~b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
  end

  assign diff_o = p ^ c[3:0];
  assign cout_o = c[4];
endmodule

module op1_sub_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] op_1,
  input  logic [11:0] op_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] result,
  output logic        borrow,
  output logic        zero,
  output logic        ovf
);
  logic       s1_en, s2_en;
  logic       s1_valid_q, s2_valid_q;
  logic [3:0] a_hi_q, b_hi_q, d_lo_q;
  logic       c4_q;
  logic [3:0] d_lo_d, d_hi_d;
  logic       c4_d, c8_d;
  logic [7:0] diff_d;
  logic [7:0] res_q;
  logic       borrow_q, zero_q, ovf_q;
  logic       unused_hi;

  // The upper operand nibble is outside the 8-bit arithmetic core.
  assign unused_hi = ^{op_1[11:8], op_2[11:8]};

  // No skid buffer: a stalled output backs pressure straight to the input.
  assign s2_en     = !s2_valid_q || out_ready;
  assign s1_en     = !s1_valid_q || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid_q;

  op1_sub_cla4 u_lo (
    .a_i   (op_1[3:0]),
    .b_i   (op_2[3:0]),
    .cin_i (1'b1),
    .diff_o(d_lo_d),
    .cout_o(c4_d)
  );

  op1_sub_cla4 u_hi (
    .a_i   (a_hi_q),
    .b_i   (b_hi_q),
    .cin_i (c4_q),
    .diff_o(d_hi_d),
    .cout_o(c8_d)
  );

  assign diff_d = {d_hi_d, d_lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_hi_q     <= 4'h0;
      b_hi_q     <= 4'h0;
      d_lo_q     <= 4'h0;
      c4_q       <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_hi_q <= op_1[7:4];
        b_hi_q <= op_2[7:4];
        d_lo_q <= d_lo_d;
        c4_q   <= c4_d;
      end
    end
  end

  // Stage 2 data only moves on a real transfer so results stay put when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      res_q      <= 8'h00;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q    <= diff_d;
        borrow_q <= ~c8_d;
        zero_q   <= (diff_d == 8'h00);
        ovf_q    <= (a_hi_q[3] ^ b_hi_q[3]) & (d_hi_d[3] ^ a_hi_q[3]);
      end
    end
  end

  assign result = {4'h0, res_q};
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_op1_sub_pipe.sv
// Bench for op1_sub_pipe: directed arithmetic cases, stall, mid-stream reset,
// and a randomized handshake run against a queue-based reference model.

module tb_op1_sub_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] op_1 = '0;
  logic [11:0] op_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] result;
  logic        borrow, zero, ovf;

  int vec  = 0;
  int miss = 0;
  int edge_n = 0;

  typedef struct {
    logic [11:0] res;
    logic        b;
    logic        z;
    logic        o;
    int          acc;
  } exp_t;

  op1_sub_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_1(op_1), .op_2(op_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .borrow(borrow), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Reference: plain integer arithmetic on the low bytes.
  function automatic exp_t model(input logic [11:0] x, input logic [11:0] y);
    exp_t m;
    int a, b, sa, sb, d;
    a  = int'(x[7:0]);
    b  = int'(y[7:0]);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    d  = (a - b + 256) % 256;
    m.res = 12'(d);
    m.b   = (a < b);
    m.z   = (d == 0);
    m.o   = ((sa - sb) > 127) || ((sa - sb) < -128);
    m.acc = 0;
    return m;
  endfunction

  task automatic test_reset();
    #1;
    vec++;
    if (out_valid !== 1'b0 || result !== 12'h000 || borrow !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      miss++;
      $display("FAIL reset_state: got ov=%b res=%h b=%b z=%b o=%b, want 0/000/0/0/0", out_valid, result, borrow, zero, ovf);
    end
    step();
    rst = 1'b0;
    #1;
    vec++;
    if (in_ready !== 1'b1) begin
      miss++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [11:0] ta [6], tb [6], tr [6];
    logic [2:0]  tf [6];
    ta = '{12'h005, 12'h003, 12'h080, 12'h07F, 12'hFA5, 12'hF10};
    tb = '{12'h003, 12'h005, 12'h001, 12'h0FF, 12'h3A5, 12'h001};
    tr = '{12'h002, 12'h0FE, 12'h07F, 12'h080, 12'h000, 12'h00F};
    tf = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000}; // {borrow,zero,ovf}
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op_1 = ta[i];
      op_2 = tb[i];
      step();
      in_valid = 1'b0;
      vec++;
      if (out_valid !== 1'b0) begin
        miss++;
        $display("FAIL dir%0d_early: out_valid=%b after one edge, want 0", i, out_valid);
      end
      step();
      vec++;
      if (out_valid !== 1'b1 || result !== tr[i] || {borrow, zero, ovf} !== tf[i]) begin
        miss++;
        $display("FAIL dir%0d_result: got ov=%b res=%h bzo=%b, want 1/%h/%b", i, out_valid, result, {borrow, zero, ovf}, tr[i], tf[i]);
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [11:0] want [3];
    want = '{12'h00F, 12'h01E, 12'h02D};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_1 = 12'h010; op_2 = 12'h001;
    step();
    op_1 = 12'h020; op_2 = 12'h002;
    step();
    op_1 = 12'h030; op_2 = 12'h003;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (out_valid !== 1'b1 || result !== 12'h00F || in_ready !== 1'b0) begin
        miss++;
        $display("FAIL stall_hold%0d: got ov=%b res=%h ir=%b, want 1/00F/0", i, out_valid, result, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    vec++;
    if (in_ready !== 1'b1) begin
      miss++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    for (int j = 0; j < 3; j++) begin
      vec++;
      if (out_valid !== 1'b1 || result !== want[j]) begin
        miss++;
        $display("FAIL stall_drain%0d: got ov=%b res=%h, want 1/%h", j, out_valid, result, want[j]);
      end
      step();
      in_valid = 1'b0;
    end
    vec++;
    if (out_valid !== 1'b0) begin
      miss++;
      $display("FAIL stall_empty: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_1 = 12'h055; op_2 = 12'h011;
    step();
    op_1 = 12'h066; op_2 = 12'h022;
    step();
    in_valid = 1'b0;
    vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miss++;
      $display("FAIL rmid_full: got ov=%b ir=%b, want 1/0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if (out_valid !== 1'b0 || result !== 12'h000 || {borrow, zero, ovf} !== 3'b000) begin
      miss++;
      $display("FAIL rmid_async: got ov=%b res=%h bzo=%b, want 0/000/000", out_valid, result, {borrow, zero, ovf});
    end
    step();
    rst = 1'b0;
    #1;
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miss++;
      $display("FAIL rmid_after: got ir=%b ov=%b, want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_1 = 12'h009; op_2 = 12'h004;
    step();
    in_valid = 1'b0;
    vec++;
    if (out_valid !== 1'b0) begin
      miss++;
      $display("FAIL rmid_early: out_valid=%b want 0", out_valid);
    end
    step();
    vec++;
    if (out_valid !== 1'b1 || result !== 12'h005 || {borrow, zero, ovf} !== 3'b000) begin
      miss++;
      $display("FAIL rmid_op: got ov=%b res=%h bzo=%b, want 1/005/000", out_valid, result, {borrow, zero, ovf});
    end
    step();
  endtask

  // Items in flight live in a queue tagged with their accept edge; an item is
  // visible at the output from the edge after it was accepted, in order.
  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit   exp_ov, exp_ir;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit drain;
      drain     = (cyc >= 380);
      in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      out_ready = drain ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      op_1      = 12'($urandom);
      op_2      = 12'($urandom);
      #1;
      exp_ov = (q.size() > 0) && (q[0].acc < edge_n);
      exp_ir = (q.size() < 2) || out_ready;
      vec++;
      if (out_valid !== exp_ov || in_ready !== exp_ir) begin
        miss++;
        $display("FAIL rnd_ctl@%0d: got ov=%b ir=%b, want %b/%b", cyc, out_valid, in_ready, exp_ov, exp_ir);
      end
      if (exp_ov) begin
        vec++;
        if (result !== q[0].res || {borrow, zero, ovf} !== {q[0].b, q[0].z, q[0].o}) begin
          miss++;
          $display("FAIL rnd_data@%0d: got res=%h bzo=%b, want %h/%b", cyc, result, {borrow, zero, ovf}, q[0].res, {q[0].b, q[0].z, q[0].o});
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        e = model(op_1, op_2);
        e.acc = edge_n + 1;
        q.push_back(e);
      end
      step();
    end
    vec++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miss++;
      $display("FAIL rnd_drain: %0d items left, out_valid=%b, want 0/0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
